padded_sliding_window: RTL and testbench

PADDED_SLIDING_WINDOW -- requirements
Module: padded_sliding_window

---
 rtl/sliding_window_pkg.sv | 24 ++
 rtl/window_line_buffer.sv | 32 +++
 rtl/padded_sliding_window.sv | 163 ++++++++++++++++
 tb/tb_padded_sliding_window.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sliding_window_pkg.sv
// Shared types for the padded sliding-window block: border handling mode and
// window-geometry helpers used to decide whether a window tap lies inside the frame.
package sliding_window_pkg;

  typedef enum logic {
    VALID_ONLY = 1'b0,
    ZERO_PAD   = 1'b1
  } border_mode_t;

  localparam int COORD_MAX_BITS = 32;
  typedef logic [COORD_MAX_BITS-1:0] coord_t;

  typedef struct packed {
    coord_t row;
    coord_t col;
  } tap_pos_t;

  // A tap looking back_row rows up and back_col columns left of the newest pixel
  // exists only if that does not step above row 0 or left of column 0.
  function automatic logic tap_in_frame(tap_pos_t newest, coord_t back_row, coord_t back_col);
    return (newest.row >= back_row) && (newest.col >= back_col);
  endfunction

endpackage

// File: rtl/window_line_buffer.sv
// Chain of row delay lines: line NUM_LINES-1 holds the previous row, line 0 the oldest.
// Asynchronous read with synchronous write, so each read returns the pre-write contents.
module window_line_buffer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 640,
  parameter int NUM_LINES = 2,
  parameter int ADDR_W    = 10
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [WIDTH-1:0]           wdata,
  output logic [NUM_LINES*WIDTH-1:0] rdata
);

  logic [(NUM_LINES+1)*WIDTH-1:0] chain;

  assign chain[NUM_LINES*WIDTH +: WIDTH] = wdata;
  assign chain[NUM_LINES*WIDTH-1:0]      = rdata;

  // Each line is refilled from the line one row newer at the same column.
  for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata[k*WIDTH +: WIDTH] = mem[addr];

    always_ff @(posedge clk) begin
      if (we) mem[addr] <= chain[(k+1)*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/padded_sliding_window.sv
// Streaming H x W pixel window with frame-position tracking and optional zero padding.
// out_window packing: tap [r][c] channel ch sits at bit ((r*W + c)*CHANNELS + ch)*DATA_BITS.
module padded_sliding_window
  import sliding_window_pkg::*;
#(
  parameter int DATA_BITS       = 8,
  parameter int CHANNELS        = 1,
  parameter int WINDOW_NUM_ROWS = 3,
  parameter int WINDOW_NUM_COLS = 3,
  parameter int MAX_ROW_LENGTH  = 640,
  parameter int COORD_BITS      = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [COORD_BITS-1:0]   r_row_length,
  input  logic [COORD_BITS-1:0]   r_num_rows,
  input  border_mode_t            r_border_mode,
  input  logic                    in_valid,
  input  logic                    in_sof,
  input  logic [CHANNELS*DATA_BITS-1:0] in_data,
  output logic                    out_valid,
  output logic [WINDOW_NUM_ROWS*WINDOW_NUM_COLS*CHANNELS*DATA_BITS-1:0] out_window,
  output logic [COORD_BITS-1:0]   out_row,
  output logic [COORD_BITS-1:0]   out_col,
  output logic                    out_eof
);

  localparam int H      = WINDOW_NUM_ROWS;
  localparam int W      = WINDOW_NUM_COLS;
  localparam int PIX_W  = CHANNELS * DATA_BITS;
  localparam int WIN_W  = H * W * PIX_W;
  localparam int ADDR_W = (MAX_ROW_LENGTH > 1) ? $clog2(MAX_ROW_LENGTH) : 1;
  localparam logic [COORD_BITS-1:0] ONE      = COORD_BITS'(1);
  localparam logic [COORD_BITS-1:0] ROW_BACK = COORD_BITS'(H - 1);
  localparam logic [COORD_BITS-1:0] COL_BACK = COORD_BITS'(W - 1);

  logic [COORD_BITS-1:0] col_q, col_d, row_q, row_d;
  logic [COORD_BITS-1:0] len_q, len_d, rows_q, rows_d;
  border_mode_t          mode_q, mode_d;
  logic                  cfg_live_q, cfg_live_d;
  logic [WIN_W-1:0]      win_q, win_d;
  logic [WIN_W-1:0]      out_window_q, out_window_d;
  logic                  out_valid_q, out_valid_d, out_eof_q, out_eof_d;
  logic [COORD_BITS-1:0] out_row_q, out_row_d, out_col_q, out_col_d;

  logic                  use_inputs, last_col, last_row;
  logic [COORD_BITS-1:0] cur_row, cur_col, eff_len, eff_rows;
  border_mode_t          eff_mode;
  tap_pos_t              newest;
  logic [(H-1)*PIX_W-1:0] lb_taps;
  logic [H*PIX_W-1:0]    new_col;

  window_line_buffer #(
    .WIDTH    (PIX_W),
    .DEPTH    (MAX_ROW_LENGTH),
    .NUM_LINES(H - 1),
    .ADDR_W   (ADDR_W)
  ) u_line_buffer (
    .clk  (clk),
    .we   (in_valid),
    .addr (cur_col[ADDR_W-1:0]),
    .wdata(in_data),
    .rdata(lb_taps)
  );

  assign new_col = {in_data, lb_taps};

  // Until the first pixel after reset, or on a start-of-frame pixel, the live
  // configuration inputs apply directly; otherwise the frame's latched copy does.
  always_comb begin
    use_inputs = in_sof || !cfg_live_q;
    eff_len    = use_inputs ? r_row_length  : len_q;
    eff_rows   = use_inputs ? r_num_rows    : rows_q;
    eff_mode   = use_inputs ? r_border_mode : mode_q;
    cur_col    = in_sof ? '0 : col_q;
    cur_row    = in_sof ? '0 : row_q;
    last_col   = (cur_col == eff_len - ONE);
    last_row   = (cur_row == eff_rows - ONE);
    newest     = '{row: coord_t'(cur_row), col: coord_t'(cur_col)};
  end

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    len_d        = len_q;
    rows_d       = rows_q;
    mode_d       = mode_q;
    cfg_live_d   = cfg_live_q;
    win_d        = win_q;
    out_window_d = out_window_q;
    out_valid_d  = 1'b0;
    out_eof_d    = 1'b0;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    if (in_valid) begin
      len_d      = eff_len;
      rows_d     = eff_rows;
      mode_d     = eff_mode;
      cfg_live_d = 1'b1;
      col_d      = last_col ? '0 : cur_col + ONE;
      row_d      = !last_col ? cur_row : (last_row ? '0 : cur_row + ONE);
      for (int r = 0; r < H; r++) begin
        for (int c = 0; c < W; c++) begin
          if (c == W - 1)
            win_d[(r*W + c)*PIX_W +: PIX_W] = new_col[r*PIX_W +: PIX_W];
          else
            win_d[(r*W + c)*PIX_W +: PIX_W] = win_q[(r*W + c + 1)*PIX_W +: PIX_W];
        end
      end
      // Raw taps may hold the previous row's tail or stale RAM; mask anything off-frame.
      for (int r = 0; r < H; r++) begin
        for (int c = 0; c < W; c++) begin
          out_window_d[(r*W + c)*PIX_W +: PIX_W] =
            tap_in_frame(newest, coord_t'(H - 1 - r), coord_t'(W - 1 - c)) ?
            win_d[(r*W + c)*PIX_W +: PIX_W] : '0;
        end
      end
      out_valid_d = (eff_mode == ZERO_PAD) || ((cur_row >= ROW_BACK) && (cur_col >= COL_BACK));
      out_eof_d   = out_valid_d && last_col && last_row;
      out_row_d   = cur_row;
      out_col_d   = cur_col;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      len_q        <= '0;
      rows_q       <= '0;
      mode_q       <= VALID_ONLY;
      cfg_live_q   <= 1'b0;
      out_window_q <= '0;
      out_valid_q  <= 1'b0;
      out_eof_q    <= 1'b0;
      out_row_q    <= '0;
      out_col_q    <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      len_q        <= len_d;
      rows_q       <= rows_d;
      mode_q       <= mode_d;
      cfg_live_q   <= cfg_live_d;
      out_window_q <= out_window_d;
      out_valid_q  <= out_valid_d;
      out_eof_q    <= out_eof_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
    end
  end

  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

  assign out_valid  = out_valid_q;
  assign out_window = out_window_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign out_eof    = out_eof_q;

endmodule

// File: tb/tb_padded_sliding_window.sv
// Directed bench: a 3x3 three-channel instance on 4x4 ramps and a 2x2 instance on a 12x12 edge image.
`timescale 1ns/1ps
module tb_padded_sliding_window;
  import sliding_window_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int checks   = 0;
  int failures = 0;

  logic [9:0]   a_len, a_rows, a_row, a_col;
  border_mode_t a_mode;
  logic         a_in_valid, a_in_sof, a_out_valid, a_out_eof;
  logic [23:0]  a_in_data;
  logic [215:0] a_win;

  logic [9:0]   b_len, b_rows, b_row, b_col;
  border_mode_t b_mode;
  logic         b_in_valid, b_in_sof, b_out_valid, b_out_eof;
  logic [7:0]   b_in_data;
  logic [31:0]  b_win;

  padded_sliding_window #(
    .DATA_BITS(8), .CHANNELS(3), .WINDOW_NUM_ROWS(3), .WINDOW_NUM_COLS(3),
    .MAX_ROW_LENGTH(640), .COORD_BITS(10)
  ) dut_a (
    .clk(clk), .reset(reset), .r_row_length(a_len), .r_num_rows(a_rows),
    .r_border_mode(a_mode), .in_valid(a_in_valid), .in_sof(a_in_sof), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_window(a_win), .out_row(a_row), .out_col(a_col),
    .out_eof(a_out_eof)
  );

  padded_sliding_window #(
    .DATA_BITS(8), .CHANNELS(1), .WINDOW_NUM_ROWS(2), .WINDOW_NUM_COLS(2),
    .MAX_ROW_LENGTH(640), .COORD_BITS(10)
  ) dut_b (
    .clk(clk), .reset(reset), .r_row_length(b_len), .r_num_rows(b_rows),
    .r_border_mode(b_mode), .in_valid(b_in_valid), .in_sof(b_in_sof), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_window(b_win), .out_row(b_row), .out_col(b_col),
    .out_eof(b_out_eof)
  );

  task automatic check(input string tag, input logic [215:0] obs, input logic [215:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected 3x3x3 window for a ramp image value = base + row*len + col (+ ch*64), zero off-frame.
  function automatic logic [215:0] ew(input int row, input int col, input int len, input int base);
    logic [215:0] w;
    int pr, pc;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        for (int ch = 0; ch < 3; ch++) begin
          pr = row - (2 - r);
          pc = col - (2 - c);
          if (pr >= 0 && pc >= 0) w[((r*3 + c)*3 + ch)*8 +: 8] = 8'(base + pr*len + pc + ch*64);
        end
    return w;
  endfunction

  function automatic logic [7:0] a_tap(input int r, input int c, input int ch);
    return a_win[((r*3 + c)*3 + ch)*8 +: 8];
  endfunction

  function automatic logic [7:0] edge_pix(input int r, input int c);
    if (r + c < 12) return 8'hff;
    if (r + c == 12) return (r <= 7) ? 8'h55 : 8'haa;
    return 8'h00;
  endfunction

  task automatic a_px(input bit sof, input int v);
    @(negedge clk);
    a_in_valid = 1'b1;
    a_in_sof   = sof;
    a_in_data  = {8'(v + 128), 8'(v + 64), 8'(v)};
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    @(negedge clk);
    a_in_valid = 1'b0;
    a_in_sof   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset      = 1'b1;
    a_in_valid = 1'b0;
    a_in_sof   = 1'b0;
    b_in_valid = 1'b0;
    b_in_sof   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic a_expect(input string tn, input int r, input int c, input bit zp,
                          input int len, input int rows, input int base, inout int pulses);
    bit ev;
    ev = zp || (r >= 2 && c >= 2);
    check($sformatf("%s_valid_%0d_%0d", tn, r, c), a_out_valid, ev);
    if (a_out_valid) pulses++;
    if (ev) begin
      check($sformatf("%s_win_%0d_%0d", tn, r, c), a_win, ew(r, c, len, base));
      check($sformatf("%s_row_%0d_%0d", tn, r, c), a_row, r);
      check($sformatf("%s_col_%0d_%0d", tn, r, c), a_col, c);
      check($sformatf("%s_eof_%0d_%0d", tn, r, c), a_out_eof, (r == rows-1 && c == len-1));
    end
  endtask

  task automatic a_frame(input string tn, input bit zp, input bit sof_first, input bit gaps,
                         input bit poke, input bit lit, output int pulses);
    int r, c;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      r = i / 4;
      c = i % 4;
      a_px(sof_first && i == 0, i);
      if (poke && i == 0) begin
        a_rows = 10'd7;
        a_mode = zp ? VALID_ONLY : ZERO_PAD;
      end
      a_expect(tn, r, c, zp, 4, 4, 0, pulses);
      if (lit && !zp && i == 10) begin
        check("lit_first_00", a_tap(0, 0, 0), 8'd0);
        check("lit_first_01", a_tap(0, 1, 0), 8'd1);
        check("lit_first_11", a_tap(1, 1, 0), 8'd5);
        check("lit_first_20", a_tap(2, 0, 0), 8'd8);
        check("lit_first_22_ch2", a_tap(2, 2, 2), 8'd138);
      end
      if (lit && zp && i == 0) begin
        check("lit_zp00_22", a_tap(2, 2, 0), 8'd0);
        check("lit_zp00_22_ch1", a_tap(2, 2, 1), 8'd64);
        check("lit_zp00_21", a_tap(2, 1, 0), 8'd0);
      end
      if (lit && zp && i == 4) begin
        check("lit_zp10_12", a_tap(1, 2, 0), 8'd0);
        check("lit_zp10_22", a_tap(2, 2, 0), 8'd4);
        check("lit_zp10_21", a_tap(2, 1, 0), 8'd0);
        check("lit_zp10_11_ch1", a_tap(1, 1, 1), 8'd0);
      end
      if (gaps) begin
        a_idle();
        check($sformatf("%s_idle_valid_%0d", tn, i), a_out_valid, 1'b0);
        check($sformatf("%s_idle_eof_%0d", tn, i), a_out_eof, 1'b0);
        check($sformatf("%s_idle_row_%0d", tn, i), a_row, r);
        check($sformatf("%s_idle_col_%0d", tn, i), a_col, c);
        if (r >= 2 && c >= 2) check($sformatf("%s_idle_win_%0d", tn, i), a_win, ew(r, c, 4, 0));
      end
    end
    a_idle();
  endtask

  initial begin
    int pulses, bp;
    reset = 1'b1;
    a_len = 10'd4; a_rows = 10'd4; a_mode = VALID_ONLY;
    a_in_valid = 1'b0; a_in_sof = 1'b0; a_in_data = '0;
    b_len = 10'd12; b_rows = 10'd12; b_mode = VALID_ONLY;
    b_in_valid = 1'b0; b_in_sof = 1'b0; b_in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", a_out_valid, 1'b0);
    check("rst_eof", a_out_eof, 1'b0);
    check("rst_row", a_row, 10'd0);
    check("rst_col", a_col, 10'd0);
    check("rst_win", a_win, '0);
    check("rst_b_win", b_win, '0);
    @(negedge clk);
    reset = 1'b0;

    // VALID_ONLY ramp; mid-frame config changes must not take effect
    a_frame("ramp", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, pulses);
    check("ramp_pulses", pulses, 4);

    a_mode = ZERO_PAD; a_rows = 10'd4;
    a_frame("zpad", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, pulses);
    check("zpad_pulses", pulses, 16);

    a_mode = VALID_ONLY;
    a_frame("gaps", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, pulses);
    check("gaps_pulses", pulses, 4);

    // Abandon a frame mid-way, then stream a frame with no start-of-frame marker
    for (int i = 0; i < 7; i++) a_px(i == 0, 200 + i);
    pulse_reset();
    check("midrst_valid", a_out_valid, 1'b0);
    check("midrst_win", a_win, '0);
    check("midrst_col", a_col, 10'd0);
    @(negedge clk);
    reset = 1'b0;
    a_frame("afterrst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pulses);
    check("afterrst_pulses", pulses, 4);

    // One-column image: every left-column tap is off-frame
    a_len = 10'd1; a_rows = 10'd3; a_mode = ZERO_PAD;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      a_px(i == 0, 16 + i);
      a_expect("col1", i, 0, 1'b1, 1, 3, 16, pulses);
    end
    a_idle();
    check("col1_pulses", pulses, 3);

    // 2x2 window over a 12x12 diagonal edge
    bp = 0;
    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        b_in_valid = 1'b1;
        b_in_sof   = (r == 0 && c == 0);
        b_in_data  = edge_pix(r, c);
        @(posedge clk);
        #1;
        if (b_out_valid) bp++;
        if (r == 0 && c == 0) check("edge_valid_00", b_out_valid, 1'b0);
        if (r == 8 && c == 5) begin
          check("edge_valid_85", b_out_valid, 1'b1);
          check("edge_win_85", b_win, 32'h00aa55ff);
          check("edge_row_85", b_row, 10'd8);
          check("edge_col_85", b_col, 10'd5);
        end
        if (r == 11 && c == 11) check("edge_eof", b_out_eof, 1'b1);
        if (r == 11 && c == 10) check("edge_eof_early", b_out_eof, 1'b0);
      end
    end
    @(negedge clk);
    b_in_valid = 1'b0;
    b_in_sof   = 1'b0;
    @(posedge clk);
    #1;
    check("edge_idle_valid", b_out_valid, 1'b0);
    check("edge_pulses", bp, 121);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
